// File: rtl/i2s_pkg.sv
// Shared types, channel constants and the saturating scale helper for the
// I2S stereo packer.
//   pair_state_t : pairing FSM states (WAIT_L, HAVE_L)
//   CH_LEFT/RIGHT: channel tag carried on s_axis_tlast
//   sat_scale()  : (sample <<< gain) >>> rshift, clamped to a signed out_w range
package i2s_pkg;

    typedef enum logic {
        WAIT_L = 1'b0,
        HAVE_L = 1'b1
    } pair_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // sample must arrive sign-extended to 64 bits; 64 bits covers any
    // SAMPLE_BITS+15 intermediate used here, so the shift never overflows.
    function automatic logic [31:0] sat_scale(
        input logic signed [63:0] sample,
        input logic        [3:0]  gain,
        input int unsigned        rshift,
        input int unsigned        out_w
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = (sample <<< gain) >>> rshift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_data    : write request (caller guarantees not full unless popping)
//   full              : no free entry
//   rd_en             : consumer ready; pops when an entry is present
//   rd_valid, rd_data : head entry (rd_data reads 0 while empty)
// DEPTH must be a power of two, at least 2.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             pop;

    // Extra wrap bit: equal pointers = empty, only the wrap bit differing = full.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid = !empty;
    assign pop      = rd_en && !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_stereo_packer.sv
// Pairs per-channel I2S words into packed stereo AXI-Stream words.
//   s_axis_*        : per-channel input words, tlast = channel (0 L, 1 R);
//                     never backpressured (tready is 1 whenever out of reset)
//   gain_shift      : power-of-two gain applied per accepted word
//   m_axis_*        : {left, right} stereo words, tlast closes each frame
//   drop_count      : unpaired words discarded (saturating)
//   overflow_count  : pairs lost to a full FIFO (saturating)
module i2s_stereo_packer
    import i2s_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = 32,
    parameter int unsigned SAMPLE_BITS = 24,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned FRAME_PAIRS = 256
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_aresetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [IN_WIDTH-1:0]    s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic [3:0]             gain_shift,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [2*OUT_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [15:0]            drop_count,
    output logic [15:0]            overflow_count
);

    localparam int unsigned FCW = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
    localparam int unsigned FW  = 2 * OUT_WIDTH + 1;

    logic signed [SAMPLE_BITS-1:0] sample;
    logic                          accept;

    logic                 stg_valid;
    logic                 stg_ch;
    logic [OUT_WIDTH-1:0] stg_val;
    logic [OUT_WIDTH-1:0] left_q;

    pair_state_t state_q, state_d;
    logic        load_left;
    logic        push;
    logic        drop_inc;

    logic           fifo_full;
    logic           push_ok;
    logic           pop;
    logic [FCW-1:0] frame_cnt;
    logic           frame_last;
    logic [FW-1:0]  fifo_rd_data;

    assign sample = s_axis_tdata[IN_WIDTH-1 -: SAMPLE_BITS];
    assign accept = s_axis_tvalid && s_axis_tready;

    generate
        if (SAMPLE_BITS < IN_WIDTH) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^s_axis_tdata[IN_WIDTH-SAMPLE_BITS-1:0];
        end
    endgenerate

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
        end
    end

    // Scale stage: one registered word per accepted input.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            stg_valid <= 1'b0;
            stg_ch    <= CH_LEFT;
            stg_val   <= '0;
        end else begin
            stg_valid <= accept;
            if (accept) begin
                stg_ch  <= s_axis_tlast;
                stg_val <= OUT_WIDTH'(sat_scale(
                    {{(64 - SAMPLE_BITS){sample[SAMPLE_BITS-1]}}, sample},
                    gain_shift, SAMPLE_BITS - OUT_WIDTH, OUT_WIDTH));
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= WAIT_L;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_left = 1'b0;
        push      = 1'b0;
        drop_inc  = 1'b0;
        if (stg_valid) begin
            case (state_q)
                WAIT_L: begin
                    if (stg_ch == CH_LEFT) begin
                        load_left = 1'b1;
                        state_d   = HAVE_L;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                HAVE_L: begin
                    if (stg_ch == CH_RIGHT) begin
                        push    = 1'b1;
                        state_d = WAIT_L;
                    end else begin
                        load_left = 1'b1;
                        drop_inc  = 1'b1;
                    end
                end
                default: state_d = WAIT_L;
            endcase
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            left_q <= '0;
        end else if (load_left) begin
            left_q <= stg_val;
        end
    end

    // A full FIFO still takes the pair when the head leaves in the same cycle.
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign push_ok    = push && (!fifo_full || pop);
    assign frame_last = (frame_cnt == FCW'(FRAME_PAIRS - 1));

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            frame_cnt <= '0;
        end else if (push_ok) begin
            frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            drop_count     <= '0;
            overflow_count <= '0;
        end else begin
            if (drop_inc && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (push && !push_ok && (overflow_count != '1)) begin
                overflow_count <= overflow_count + 1'b1;
            end
        end
    end

    axis_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (s_axis_aclk),
        .rst_n    (s_axis_aresetn),
        .wr_en    (push_ok),
        .wr_data  ({frame_last, left_q, stg_val}),
        .full     (fifo_full),
        .rd_en    (m_axis_tready),
        .rd_valid (m_axis_tvalid),
        .rd_data  (fifo_rd_data)
    );

    assign m_axis_tlast = fifo_rd_data[FW-1];
    assign m_axis_tdata = fifo_rd_data[FW-2:0];

endmodule

// File: doc/i2s_stereo_packer.md
# i2s_stereo_packer

Downstream stage of the I2S receiver: consumes its AXI-Stream of per-channel 32-bit words, extracts the left-justified signed sample, applies a power-of-two gain with saturation, and pairs left and right into one packed 32-bit stereo word. Output is an AXI-Stream with a small FIFO and DMA-friendly framing via `tlast`. The upstream receiver does not honour backpressure, so this block never stalls its input. Overruns are dropped and counted.

## Interface
- `IN_WIDTH`, 32: input word width
- `SAMPLE_BITS`, 24: valid signed sample bits, MSB-aligned in the input word
- `OUT_WIDTH`, 16: per-channel output width; output word is 2*OUT_WIDTH
- `FIFO_DEPTH`, 4: output FIFO entries, power of two
- `FRAME_PAIRS`, 256: stereo pairs per output frame
- `s_axis_aclk`  in  1  single clock for the whole block
- `s_axis_aresetn`  in  1  reset, asynchronous, active-low
- `s_axis_tvalid`  in  1  input word valid
- `s_axis_tready`  out  1  0 in reset, constant 1 otherwise
- `s_axis_tdata`  in  IN_WIDTH  channel word
- `s_axis_tlast`  in  1  0 = left channel, 1 = right channel
- `gain_shift`  in  4  left-shift gain 0..15, sampled per accepted word
- `m_axis_tvalid`  out  1  stereo word available
- `m_axis_tready`  in  1  consumer ready
- `m_axis_tdata`  out  2*OUT_WIDTH  {left[OUT_WIDTH-1:0], right[OUT_WIDTH-1:0]}
- `m_axis_tlast`  out  1  high on the last pair of each frame
- `drop_count`  out  16  unpaired words discarded, saturating
- `overflow_count`  out  16  pairs lost to a full FIFO, saturating

## Operation
- A word is accepted when `s_axis_tvalid` is high and the block is out of reset.
- Sample extraction: `sample = signed(s_axis_tdata[IN_WIDTH-1 -: SAMPLE_BITS])`.
- Scaling: `scaled = (sample <<< gain_shift) >>> (SAMPLE_BITS-OUT_WIDTH)`.
  - Compute at SAMPLE_BITS+15 bits; the right shift is arithmetic (floor).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Pairing FSM:
  - WAIT_L, left word: store scaled left, go to HAVE_L.
  - WAIT_L, right word: discard it, `drop_count`++, stay in WAIT_L.
  - HAVE_L, right word: form the pair, push it to the FIFO, go to WAIT_L.
  - HAVE_L, left word: replace the stored left, `drop_count`++, stay in HAVE_L.
- Push when the FIFO is full and there is no pop in the same cycle: the pair is dropped and `overflow_count`++. The FSM still returns to WAIT_L.
- Push and pop in the same cycle while full: both succeed.
- Frame counter:
  - Counts successfully pushed pairs, 0..FRAME_PAIRS-1, and wraps to 0.
  - A pair written at count FRAME_PAIRS-1 carries `tlast` = 1.
  - Dropped pairs do not advance the counter.
- Both status counters saturate at 0xFFFF.

## Timing
- Reset values: `s_axis_tready` 0; `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast` all 0; both counters 0; FSM in WAIT_L; FIFO empty; frame counter 0. `s_axis_tready` rises in the first cycle after deassertion.
- Pipeline:
  - Cycle N: word accepted.
  - Cycle N+1: scaled value registered.
  - End of N+1: the FIFO write of a completed pair.
  - Cycle N+2: `m_axis_tvalid` high, for a right word accepted at N with an empty FIFO.
- Input words may arrive on consecutive cycles, so throughput is 1 word per cycle.
- Output handshake follows AXI-Stream:
  - `m_axis_tdata` and `m_axis_tlast` are held stable while `m_axis_tvalid` is high and `m_axis_tready` is low.
  - An entry pops when both are high.
  - `m_axis_tvalid` does not depend combinationally on `m_axis_tready`.
- `gain_shift` changes take effect on the next accepted word. A pair may therefore mix gains.
- Reset asserted mid-operation: the partial pair, FIFO contents and in-flight pipeline stage are discarded immediately (asynchronous). No output handshake completes during reset.

## Structure
- Package `i2s_pkg`:
  - `pair_state_t` enum (WAIT_L, HAVE_L).
  - Channel constants `CH_LEFT` = 0, `CH_RIGHT` = 1.
  - Saturating-scale function, parameterised by widths.
- Sub-module `axis_sync_fifo`:
  - Depth and width parameterised, first-word-fall-through.
  - Full/empty from pointers with an extra wrap bit.
  - Same async active-low reset.
- Top level holds the extraction, scale stage, FSM, frame counter and status counters.

## Test plan
- Gain and saturation, with gain 0:
  - Left 0x12345600 then right 0xFFFF0000 -> tdata 0x1234FFFF, arriving exactly 2 cycles after the right word.
  - Repeat at gain 4 -> 0x7FFFFFF0 (left saturates; right -256<<4 gives -16).
- Misalignment:
  - Sequence R, L, L, R -> one output pair built from the second L; `drop_count` = 2.
- Backpressure:
  - Hold `m_axis_tready` low and send 6 pairs (FIFO_DEPTH=4) -> 4 entries held; `overflow_count` = 2.
  - Release -> the first 4 pairs are drained in order, with data stable while stalled.
- Full with simultaneous pop:
  - FIFO full, `m_axis_tready` high in the cycle the next pair is written -> no overflow, and order is preserved.
- Framing:
  - FRAME_PAIRS = 4, 9 pairs -> `tlast` on pairs 4 and 8 only.
- Reset mid-frame:
  - Assert `s_axis_aresetn` with a stored left and 2 FIFO entries.
  - Outputs are 0 immediately. After release, a new L/R pair emits with `tlast` counting from 0.
